// File: rtl/alu_pipe_pkg.sv
// Shared types for the two-stage ALU pipeline: opcode encoding, the
// width-independent control portion of each stage register, and the
// flag-update rule applied when an op moves from S1 to S2.
package alu_pipe_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_SHL  = 4'd2,
      OP_SHR  = 4'd3,
      OP_PASS = 4'd4,
      OP_LDLO = 4'd5,
      OP_LDHI = 4'd6,
      OP_NOP  = 4'd7,
      OP_CEQ  = 4'd8,
      OP_CLT  = 4'd9,
      OP_CGT  = 4'd10,
      OP_FNOT = 4'd11,
      OP_FAND = 4'd12,
      OP_FMOV = 4'd13,
      OP_JMP  = 4'd14,
      OP_JMPF = 4'd15
   } alu_op_t;

   // S1 control: the accepted opcode plus the single operand bit the flag
   // logic needs. For compares this is the compare outcome (computed at
   // accept time, it does not depend on the flag); otherwise it is B[0].
   typedef struct packed {
      logic    valid;
      alu_op_t op;
      logic    opnd_bit;
   } s1_ctrl_t;

   // S2 control: everything about the finished op that is not a data word.
   typedef struct packed {
      logic valid;
      logic flag;
      logic branch;
   } s2_ctrl_t;

   // Flag value after executing op, given the current flag register.
   function automatic logic next_flag(input alu_op_t op,
                                      input logic    opnd_bit,
                                      input logic    flag);
      logic nf;
      case (op)
         OP_CEQ,
         OP_CLT,
         OP_CGT,
         OP_FMOV: nf = opnd_bit;
         OP_FNOT: nf = ~flag;
         OP_FAND: nf = flag & opnd_bit;
         default: nf = flag;
      endcase
      return nf;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Pure combinational data path of the ALU: computes the data result of one
// operation. Flag and branch behaviour live in the pipeline, not here.
module alu_core
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IMM_W = WIDTH / 2
) (
   input  alu_op_t          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [IMM_W-1:0] imm,
   output logic [WIDTH-1:0] result
);

   localparam int SH_W = $clog2(WIDTH);

   // Only the low bits of B select the shift distance; upper bits ignored.
   logic [SH_W-1:0] shamt_s;
   assign shamt_s = b[SH_W-1:0];

   // Select the data result; every op not listed forwards operand A.
   always_comb begin
      result = a;
      case (op)
         OP_ADD:  result = a + b;
         OP_SUB:  result = a + ~b + {{(WIDTH-1){1'b0}}, 1'b1};
         OP_SHL:  result = a << shamt_s;
         OP_SHR:  result = a >> shamt_s;
         OP_LDLO: result = {a[WIDTH-1:IMM_W], imm};
         OP_LDHI: result = {imm, a[IMM_W-1:0]};
         default: result = a;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline.
// S1 captures the accepted op with its data result already computed.
// On the S1->S2 transfer the flag register is read and updated, so flag
// ops retire strictly in program order with no bubble between them.
// S2 drives the outputs directly and holds them while the consumer stalls.
module alu_pipe
   import alu_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int IMM_W = WIDTH / 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [IMM_W-1:0] in_imm,
   input  logic [WIDTH-1:0] in_target,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_flag,
   output logic             out_branch,
   output logic [WIDTH-1:0] out_target
);

   alu_op_t          op_s;
   logic [WIDTH-1:0] core_result_s;
   logic             opnd_bit_s;

   s1_ctrl_t         s1_q, s1_d;
   logic [WIDTH-1:0] s1_result_q, s1_result_d;
   logic [WIDTH-1:0] s1_target_q, s1_target_d;

   s2_ctrl_t         s2_q, s2_d;
   logic [WIDTH-1:0] s2_result_q, s2_result_d;
   logic [WIDTH-1:0] s2_target_q, s2_target_d;

   logic             flag_q, flag_d;

   logic             s1_adv_s;
   logic             s1_xfer_s;
   logic             new_flag_s;
   logic             branch_s;

   assign op_s = alu_op_t'(in_op);

   alu_core #(
      .WIDTH (WIDTH),
      .IMM_W (IMM_W)
   ) u_core (
      .op     (op_s),
      .a      (in_a),
      .b      (in_b),
      .imm    (in_imm),
      .result (core_result_s)
   );

   // S1 may move on whenever S2 is empty or is being drained this cycle;
   // the same condition frees S1 for a new op, giving full throughput.
   assign s1_adv_s  = !s2_q.valid || out_ready;
   assign in_ready  = !s1_q.valid || s1_adv_s;
   assign s1_xfer_s = s1_q.valid && s1_adv_s;

   // Reduce the compare ops to one bit at accept time so S1 need not keep B.
   always_comb begin
      opnd_bit_s = in_b[0];
      case (op_s)
         OP_CEQ:  opnd_bit_s = (in_a == in_b);
         OP_CLT:  opnd_bit_s = (in_a < in_b);
         OP_CGT:  opnd_bit_s = (in_a > in_b);
         default: opnd_bit_s = in_b[0];
      endcase
   end

   // S1 next state: load whenever it has room, otherwise hold.
   always_comb begin
      s1_d        = s1_q;
      s1_result_d = s1_result_q;
      s1_target_d = s1_target_q;
      if (in_ready) begin
         s1_d.valid    = in_valid;
         s1_d.op       = op_s;
         s1_d.opnd_bit = opnd_bit_s;
         s1_result_d   = core_result_s;
         s1_target_d   = in_target;
      end else begin
         s1_d        = s1_q;
         s1_result_d = s1_result_q;
         s1_target_d = s1_target_q;
      end
   end

   // Flag and branch outcome of the op sitting in S1, against the live flag.
   always_comb begin
      new_flag_s = next_flag(s1_q.op, s1_q.opnd_bit, flag_q);
      branch_s   = 1'b0;
      case (s1_q.op)
         OP_JMP:  branch_s = 1'b1;
         OP_JMPF: branch_s = flag_q;
         default: branch_s = 1'b0;
      endcase
   end

   // S2 and flag next state: take the S1 op on transfer, empty on a bare
   // drain, otherwise hold everything so outputs stay stable under stall.
   always_comb begin
      s2_d        = s2_q;
      s2_result_d = s2_result_q;
      s2_target_d = s2_target_q;
      flag_d      = flag_q;
      if (s1_xfer_s) begin
         s2_d.valid  = 1'b1;
         s2_d.flag   = new_flag_s;
         s2_d.branch = branch_s;
         s2_result_d = s1_result_q;
         s2_target_d = branch_s ? s1_target_q : {WIDTH{1'b0}};
         flag_d      = new_flag_s;
      end else if (s1_adv_s) begin
         s2_d.valid  = 1'b0;
      end else begin
         s2_d        = s2_q;
         s2_result_d = s2_result_q;
         s2_target_d = s2_target_q;
         flag_d      = flag_q;
      end
   end

   // Pipeline state registers; reset discards every in-flight op.
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q        <= '0;
         s1_result_q <= {WIDTH{1'b0}};
         s1_target_q <= {WIDTH{1'b0}};
         s2_q        <= '0;
         s2_result_q <= {WIDTH{1'b0}};
         s2_target_q <= {WIDTH{1'b0}};
         flag_q      <= 1'b0;
      end else begin
         s1_q        <= s1_d;
         s1_result_q <= s1_result_d;
         s1_target_q <= s1_target_d;
         s2_q        <= s2_d;
         s2_result_q <= s2_result_d;
         s2_target_q <= s2_target_d;
         flag_q      <= flag_d;
      end
   end

   assign out_valid  = s2_q.valid;
   assign out_result = s2_result_q;
   assign out_flag   = s2_q.flag;
   assign out_branch = s2_q.branch;
   assign out_target = s2_target_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed spot checks plus randomized
// traffic with random backpressure, scored against a behavioural model.
module tb_alu_pipe;

   localparam int W  = 32;
   localparam int IW = 16;

   typedef struct packed {
      logic [W-1:0] result;
      logic         flag;
      logic         branch;
      logic [W-1:0] target;
   } exp_t;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_op;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic [IW-1:0] in_imm;
   logic [W-1:0]  in_target;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_result;
   logic          out_flag;
   logic          out_branch;
   logic [W-1:0]  out_target;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   logic mflag;

   always #5 clock = ~clock;

   alu_pipe #(.WIDTH(W), .IMM_W(IW)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_imm     (in_imm),
      .in_target  (in_target),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flag   (out_flag),
      .out_branch (out_branch),
      .out_target (out_target)
   );

   // Architectural model: executes one op in program order on its own flag.
   function automatic exp_t model_op(input logic [3:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [IW-1:0] imm,
                                     input logic [W-1:0] tgt);
      exp_t e;
      e.result = a;
      e.branch = 1'b0;
      e.target = '0;
      case (op)
         4'd0:  e.result = a + b;
         4'd1:  e.result = a - b;
         4'd2:  e.result = a << (b % 32'd32);
         4'd3:  e.result = a >> (b % 32'd32);
         4'd5:  e.result = {a[W-1:IW], imm};
         4'd6:  e.result = {imm, a[IW-1:0]};
         4'd8:  mflag = (a == b);
         4'd9:  mflag = (a < b);
         4'd10: mflag = (a > b);
         4'd11: mflag = !mflag;
         4'd12: mflag = mflag && b[0];
         4'd13: mflag = b[0];
         4'd14: begin e.branch = 1'b1; e.target = tgt; end
         4'd15: begin e.branch = mflag; e.target = mflag ? tgt : '0; end
         default: ;
      endcase
      e.flag = mflag;
      return e;
   endfunction

   // One clock cycle: drive inputs, sample handshake and outputs before the
   // edge, log accepted ops into the model queue.
   task automatic cyc(input logic v, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [IW-1:0] imm,
                      input logic [W-1:0] tgt, input logic ordy,
                      output logic acc, output logic ov, output logic rdy,
                      output exp_t obs);
      in_valid = v; in_op = op; in_a = a; in_b = b; in_imm = imm;
      in_target = tgt; out_ready = ordy;
      #2;
      rdy = in_ready;
      ov  = out_valid;
      acc = in_valid && in_ready;
      obs = {out_result, out_flag, out_branch, out_target};
      if (acc) exp_q.push_back(model_op(op, a, b, imm, tgt));
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_result !== '0) begin n_bad++; $display("FAIL reset_result: got %h want 0", out_result); end
      n_cmp++; if ({out_flag, out_branch} !== 2'b00) begin n_bad++; $display("FAIL reset_flag_branch: got %b%b want 00", out_flag, out_branch); end
      n_cmp++; if (out_target !== '0) begin n_bad++; $display("FAIL reset_target: got %h want 0", out_target); end
   endtask

   task automatic test_latency();
      logic acc, ov, rdy; exp_t obs, e;
      cyc(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
      n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL lat_accept: got %b want 1", acc); end
      cyc(1'b0, 4'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
      n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL lat_early: out_valid %b want 0 one cycle after accept", ov); end
      cyc(1'b0, 4'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
      n_cmp++;
      if (ov !== 1'b1 || obs.result !== 32'h0) begin
         n_bad++; $display("FAIL lat_add_wrap: valid %b result %h want 1 / 00000000", ov, obs.result);
      end
      if (ov === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL lat_model: got %h want %h", obs, e); end
      end
   endtask

   task automatic test_directed();
      logic [3:0]    t_op [8];
      logic [W-1:0]  t_a  [8];
      logic [W-1:0]  t_b  [8];
      logic [IW-1:0] t_im [8];
      exp_t          lit  [8];
      logic acc, ov, rdy; exp_t obs, e;
      int i = 0, k = 0;
      t_op[0] = 4'd1;  t_a[0] = 32'd5;          t_b[0] = 32'd7;          t_im[0] = 16'h0;
      t_op[1] = 4'd2;  t_a[1] = 32'h1;          t_b[1] = 32'h21;         t_im[1] = 16'h0;
      t_op[2] = 4'd3;  t_a[2] = 32'h8000_0000;  t_b[2] = 32'd31;         t_im[2] = 16'h0;
      t_op[3] = 4'd6;  t_a[3] = 32'h1234_5678;  t_b[3] = 32'h0;          t_im[3] = 16'hABCD;
      t_op[4] = 4'd5;  t_a[4] = 32'h1234_5678;  t_b[4] = 32'h0;          t_im[4] = 16'hABCD;
      t_op[5] = 4'd9;  t_a[5] = 32'd1;          t_b[5] = 32'd2;          t_im[5] = 16'h0;
      t_op[6] = 4'd11; t_a[6] = 32'h0;          t_b[6] = 32'h0;          t_im[6] = 16'h0;
      t_op[7] = 4'd15; t_a[7] = 32'h0;          t_b[7] = 32'h0;          t_im[7] = 16'h0;
      lit[0] = {32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0};
      lit[1] = {32'h0000_0002, 1'b0, 1'b0, 32'h0};
      lit[2] = {32'h0000_0001, 1'b0, 1'b0, 32'h0};
      lit[3] = {32'hABCD_5678, 1'b0, 1'b0, 32'h0};
      lit[4] = {32'h1234_ABCD, 1'b0, 1'b0, 32'h0};
      lit[5] = {32'h0000_0001, 1'b1, 1'b0, 32'h0};
      lit[6] = {32'h0000_0000, 1'b0, 1'b0, 32'h0};
      lit[7] = {32'h0000_0000, 1'b0, 1'b0, 32'h0};
      for (int c = 0; c < 40 && k < 8; c++) begin
         if (i < 8) cyc(1'b1, t_op[i], t_a[i], t_b[i], t_im[i], 32'h100, 1'b1, acc, ov, rdy, obs);
         else       cyc(1'b0, 4'd7, 32'h0, 32'h0, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
         if (i < 8 && !acc) begin n_cmp++; n_bad++; $display("FAIL dir_no_bubble: op %0d not accepted", i); end
         if (acc) i++;
         if (ov) begin
            n_cmp++; if (obs !== lit[k]) begin n_bad++; $display("FAIL dir_op%0d: got %h want %h", k, obs, lit[k]); end
            e = exp_q.pop_front();
            n_cmp++; if (obs !== e) begin n_bad++; $display("FAIL dir_model%0d: got %h want %h", k, obs, e); end
            k++;
         end
      end
      n_cmp++; if (k !== 8) begin n_bad++; $display("FAIL dir_timeout: got %0d outputs want 8", k); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] ba [3];
      logic acc, ov, rdy; exp_t obs, e;
      int i = 0, k = 0;
      for (int j = 0; j < 3; j++) ba[j] = $urandom;
      for (int c = 0; c < 5; c++) begin
         if (i < 3) cyc(1'b1, 4'd0, ba[i], 32'd17, 16'h0, 32'h0, 1'b0, acc, ov, rdy, obs);
         else       cyc(1'b0, 4'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b0, acc, ov, rdy, obs);
         if (acc) i++;
         if (c >= 2) begin
            n_cmp++; if (rdy !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, rdy); end
            n_cmp++;
            if (ov !== 1'b1 || exp_q.size() == 0 || obs !== exp_q[0]) begin
               n_bad++; $display("FAIL bp_hold c%0d: valid %b got %h", c, ov, obs);
            end
         end
      end
      n_cmp++; if (i !== 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", i); end
      for (int c = 0; c < 20 && k < 3; c++) begin
         if (i < 3) cyc(1'b1, 4'd0, ba[i], 32'd17, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
         else       cyc(1'b0, 4'd0, 32'h0, 32'h0, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
         if (acc) i++;
         if (ov) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs !== e || obs.result !== ba[k] + 32'd17) begin
               n_bad++; $display("FAIL bp_order%0d: got %h want %h", k, obs, e);
            end
            k++;
         end
      end
      n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL bp_drain: got %0d outputs want 3", k); end
   endtask

   task automatic test_back_to_back();
      logic acc, ov, rdy; exp_t obs, e;
      logic v, ordy; logic [3:0] op; logic [W-1:0] a, b, t; logic [IW-1:0] im;
      int seen = 0;
      for (int c = 0; c < 400; c++) begin
         v    = ($urandom_range(3, 0) != 0);
         ordy = ($urandom_range(3, 0) != 0) || (c >= 360);
         if (c >= 360) v = 1'b0;
         op = 4'($urandom_range(15, 0));
         a  = ($urandom_range(1, 0) != 0) ? 32'($urandom_range(7, 0)) : $urandom;
         b  = ($urandom_range(3, 0) == 0) ? a :
              (($urandom_range(1, 0) != 0) ? 32'($urandom_range(7, 0)) : $urandom);
         im = 16'($urandom);
         t  = $urandom;
         cyc(v, op, a, b, im, t, ordy, acc, ov, rdy, obs);
         if (ov && ordy) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++; $display("FAIL rand_extra: unexpected output %h", obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin n_bad++; $display("FAIL rand_op%0d: got %h want %h", seen, obs, e); end
            end
            seen++;
         end
      end
      n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_lost: %0d ops never emerged", exp_q.size()); end
      n_cmp++; if (seen < 100) begin n_bad++; $display("FAIL rand_volume: got %0d outputs want >=100", seen); end
   endtask

   task automatic test_reset_flush();
      logic acc, ov, rdy; exp_t obs, e;
      int outs = 0;
      cyc(1'b1, 4'd13, 32'h0, 32'h1, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
      for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
         cyc(1'b0, 4'd7, 32'h0, 32'h0, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
         if (ov) begin
            e = exp_q.pop_front();
            n_cmp++; if (obs !== e || obs.flag !== 1'b1) begin n_bad++; $display("FAIL rf_fmov: got %h want %h", obs, e); end
         end
      end
      cyc(1'b1, 4'd8, 32'h5, 32'h5, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
      cyc(1'b1, 4'd0, 32'h1, 32'h2, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      exp_q.delete();
      mflag = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rf_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_flag !== 1'b0) begin n_bad++; $display("FAIL rf_out_flag: got %b want 0", out_flag); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rf_in_ready: got %b want 1", in_ready); end
      cyc(1'b1, 4'd15, 32'h0, 32'h0, 16'h0, 32'h100, 1'b1, acc, ov, rdy, obs);
      for (int c = 0; c < 8; c++) begin
         cyc(1'b0, 4'd7, 32'h0, 32'h0, 16'h0, 32'h0, 1'b1, acc, ov, rdy, obs);
         if (ov) begin
            outs++;
            n_cmp++;
            if (obs.branch !== 1'b0 || obs.target !== 32'h0 || obs.flag !== 1'b0) begin
               n_bad++; $display("FAIL rf_jmpf: branch %b target %h flag %b want 0/0/0", obs.branch, obs.target, obs.flag);
            end
         end
      end
      n_cmp++; if (outs !== 1) begin n_bad++; $display("FAIL rf_flushed: got %0d outputs want 1", outs); end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in_a = '0; in_b = '0;
      in_imm = '0; in_target = '0; out_ready = 1'b1; mflag = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      test_reset();
      test_latency();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
